// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    parameter int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    // Bit counter width for a given operand width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result valid/ready channels of the serial subtractor.
// Carries the ovf flag only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_OVERFLOW_EN
        input  ovf,
`endif
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_OVERFLOW_EN
        output ovf,
`endif
        output in_ready, out_valid, diff, borrow
    );

endinterface

// File: rtl/half_subtractor.sv
// One-bit half subtractor: difference and borrow-out of x - y.
module half_subtractor (
    input  logic x_i,
    input  logic y_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = x_i ^ y_i;
    assign bo_o = ~x_i & y_i;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, WIDTH cycles per operation.
// Optional signed-overflow flag when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              bw_q, bw_d;
    logic              d1, bo1, d_bit, bo2;

    // Full subtractor built from two half subtractors.
    half_subtractor u_hs_ab (
        .x_i  (a_sh_q[0]),
        .y_i  (b_sh_q[0]),
        .d_o  (d1),
        .bo_o (bo1)
    );

    half_subtractor u_hs_bw (
        .x_i  (d1),
        .y_i  (bw_q),
        .d_o  (d_bit),
        .bo_o (bo2)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                bw_d   = bo1 | bo2;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.diff      = res_q;
    assign bus.borrow    = bw_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb_q, b_msb_q;

    // Operand sign bits are shifted out during SHIFT, so keep a copy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (state_q == StIdle && bus.in_valid) begin
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
        end
    end

    assign bus.ovf = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner sequences, random ops.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] av, input logic [W-1:0] bv);
        int unsigned r;
        r = (int'(av) - int'(bv) + (1 << W)) % (1 << W);
        return r[W-1:0];
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
        int r;
        r = int'($signed(av)) - int'($signed(bv));
        return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endfunction

    // One full transaction; holds out_ready low for 'stall' cycles after out_valid.
    task automatic do_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] exp_d, input logic exp_b, input int stall);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check({nm, " in_ready before accept"}, bus.in_ready, 1);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        bus.out_ready = (stall == 0);
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check({nm, " latency"}, n, W);
        check({nm, " diff"}, bus.diff, exp_d);
        check({nm, " borrow"}, bus.borrow, exp_b);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({nm, " ovf"}, bus.ovf, model_ovf(av, bv));
`endif
        for (int i = 0; i < stall; i++) begin
            tick();
            if (bus.diff !== exp_d || !bus.out_valid) check({nm, " held"}, bus.diff, exp_d);
        end
        bus.out_ready = 1'b1;
        tick();
        check({nm, " in_ready after"}, bus.in_ready, 1);
        check({nm, " out_valid after"}, bus.out_valid, 0);
    endtask

    vec_t vecs[7];
    logic [W-1:0] ra, rb, held_d;
    int n;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        vecs[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, borrow: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, borrow: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'h00, diff: 8'h00, borrow: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, borrow: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0};
        vecs[5] = '{a: 8'h10, b: 8'h01, diff: 8'h0F, borrow: 1'b0};
        vecs[6] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1};

        tick();
        tick();
        rst_n = 1'b1;
        check("reset in_ready", bus.in_ready, 1);
        check("reset out_valid", bus.out_valid, 0);
        check("reset diff", bus.diff, 0);
        check("reset borrow", bus.borrow, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("reset ovf", bus.ovf, 0);
`endif

        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, 0);
        end

        // Idle outputs must not move while operands wiggle without in_valid.
        held_d = bus.diff;
        for (int i = 0; i < 4; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            tick();
            if (bus.diff !== held_d || !bus.in_ready) check("idle stable", bus.diff, held_d);
        end
        check("idle diff final", bus.diff, held_d);

        // Stalled consumer; a new operand offered meanwhile must be ignored.
        bus.a = 8'hA0;
        bus.b = 8'h0F;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check("stall latency", n, W);
        bus.a = 8'h11;
        bus.b = 8'h00;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall diff c%0d", i), bus.diff, 8'h91);
            check($sformatf("stall borrow c%0d", i), bus.borrow, 0);
            check($sformatf("stall valid c%0d", i), bus.out_valid, 1);
            check($sformatf("stall in_ready c%0d", i), bus.in_ready, 0);
            tick();
        end
        check("stall diff end", bus.diff, 8'h91);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("stall release in_ready", bus.in_ready, 1);
        check("stall release out_valid", bus.out_valid, 0);

        // Reset in the middle of SHIFT discards the operation.
        bus.a = 8'h40;
        bus.b = 8'h01;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst in_ready", bus.in_ready, 1);
        check("midrst diff", bus.diff, 0);
        n = 0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            if (bus.out_valid) n++;
        end
        check("midrst no result", n, 0);
        do_op("post rst", 8'h10, 8'h01, 8'h0F, 1'b0, 0);

        // Random operands with random consumer back-pressure.
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom);
            rb = (i % 8 == 0) ? ra : 8'($urandom);
            do_op($sformatf("rnd%0d", i), ra, rb, model_diff(ra, rb), (ra < rb),
                  int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
